dmem_arbiter: RTL and testbench

- Shares the single data memory (one write port, one combinational read port) between two requesters: port 0 = CPU load/store unit, port 1 = program loader/debug access.
- Round-robin arbitration with bounded burst ownership.
- Registered read-response path; drives the memory's write_enable, read_address, write_address and data_in directly.

---
 rtl/dmem_pkg.sv | 12 +
 rtl/dmem_arbiter_if.sv | 37 +++
 rtl/dmem_arbiter_rr_arb2.sv | 20 ++
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Holds the FSM state encoding and the default memory geometry, so the
// arbiter and the memory it drives agree on width and depth.
package dmem_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_DEPTH  = 1024;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter.
// Port 0 = CPU load/store unit, port 1 = program loader / debug access.
//   master modport: requester view (drives req/we/addr/wdata, sees gnt/rdata/rvalid)
//   slave  modport: arbiter view
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = DMEM_DATA_W
);

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              rvalid0;
    logic              rvalid1;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick, purely combinational.
//   req0, req1 : requests
//   last       : port that owned the bus most recently
//   winner     : selected port (0/1); only meaningful when a request is present
module rr_arb2
    import dmem_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

    // On contention the port that did not go last wins; otherwise the lone
    // requester wins (defaults to 0 when nobody asks).
    always_comb begin
        winner = (req0 && req1) ? ~last : req1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one write port + one combinational read port
// between two requesters with round-robin arbitration and bounded bursts.
//   clk, rst      : clock, asynchronous active-high reset
//   bus           : requester bus (dmem_arbiter_if.slave)
//   write_enable  : memory write strobe (suppressed for out-of-range addresses)
//   read_address  : memory read address  (owner's address while BUSY, else 0)
//   write_address : memory write address (owner's address while BUSY, else 0)
//   data_in       : memory write data    (owner's data while BUSY, else 0)
//   data_out      : memory combinational read data
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W    = DMEM_DATA_W,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = DMEM_DEPTH,
    parameter int BURST_MAX = 4
)(
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     bus,
    output logic              write_enable,
    output logic [ADDR_W-1:0] read_address,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    logic [0:0]        state;
    logic              owner;
    logic              last;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              rvalid0_q;
    logic              rvalid1_q;

    logic              busy;
    logic              req_o;
    logic              req_x;
    logic              we_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] wdata_o;
    logic              gnt_o;
    logic              in_range;
    logic [CNT_W:0]    cnt_inc;
    logic              burst_full;
    logic              idle_pick;
    logic [DATA_W-1:0] rd_val;

    rr_arb2 u_pick (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .last   (last),
        .winner (idle_pick)
    );

    always_comb begin
        busy     = (state == ST_BUSY);
        req_o    = owner ? bus.req1   : bus.req0;
        req_x    = owner ? bus.req0   : bus.req1;
        we_o     = owner ? bus.we1    : bus.we0;
        addr_o   = owner ? bus.addr1  : bus.addr0;
        wdata_o  = owner ? bus.wdata1 : bus.wdata0;
        gnt_o    = busy && req_o;
        // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
        in_range = {1'b0, addr_o} < (ADDR_W + 1)'(DEPTH);
        // Widened so cnt+1 cannot wrap when BURST_MAX is 2**CNT_W - 1.
        cnt_inc    = {1'b0, cnt} + (CNT_W + 1)'(1);
        burst_full = cnt_inc >= (CNT_W + 1)'(BURST_MAX);
        rd_val     = in_range ? data_out : '0;
    end

    // Everything is derived from state, so reset (which forces IDLE
    // asynchronously) silences the memory strobe immediately.
    always_comb begin
        bus.gnt0      = gnt_o && !owner;
        bus.gnt1      = gnt_o &&  owner;
        write_enable  = gnt_o && we_o && in_range;
        read_address  = busy ? addr_o  : '0;
        write_address = busy ? addr_o  : '0;
        data_in       = busy ? wdata_o : '0;
        bus.rdata0    = rdata0_q;
        bus.rdata1    = rdata1_q;
        bus.rvalid0   = rvalid0_q;
        bus.rvalid1   = rvalid1_q;
    end

    // Read-response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt_o && !we_o && !owner;
            rvalid1_q <= gnt_o && !we_o &&  owner;
            if (gnt_o && !we_o) begin
                if (owner) rdata1_q <= rd_val;
                else       rdata0_q <= rd_val;
            end
        end
    end

    // Ownership FSM and burst counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state <= ST_BUSY;
                        owner <= idle_pick;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (gnt_o) begin
                        if (burst_full && req_x) begin
                            owner <= ~owner;
                            last  <= owner;
                            cnt   <= '0;
                        end else if (cnt != CNT_W'(BURST_MAX)) begin
                            cnt <= cnt_inc[CNT_W-1:0];
                        end
                    end else if (req_x) begin
                        owner <= ~owner;
                        last  <= owner;
                        cnt   <= '0;
                    end else begin
                        state <= ST_IDLE;
                        last  <= owner;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int DEPTH     = 1024;
    localparam int BURST_MAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic              write_enable;
    logic [ADDR_W-1:0] read_address;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    dmem_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .write_enable  (write_enable),
        .read_address  (read_address),
        .write_address (write_address),
        .data_in       (data_in),
        .data_out      (data_out)
    );

    // ---------------- memory (initial content + written overlay) ----------
    logic [31:0] stream_vals [10] = '{32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'h6,
                                      32'hFFFFFFFB, 32'h4, 32'hFFFFFFFD, 32'hFFFFFFFE,
                                      32'h80000000, 32'h0};

    function automatic logic [31:0] init_val(int unsigned a);
        if (a >= 1 && a <= 10) return stream_vals[a-1];
        return (32'(a) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    logic [DATA_W-1:0] mem     [DEPTH];
    bit                written [DEPTH];

    always @(posedge clk) begin
        if (write_enable && write_address < 32'(DEPTH)) begin
            mem[write_address[9:0]]     <= data_in;
            written[write_address[9:0]] <= 1'b1;
        end
    end

    function automatic logic [31:0] mem_view(int unsigned a);
        return written[a] ? mem[a] : init_val(a);
    endfunction

    assign data_out = (read_address < 32'(DEPTH)) ? mem_view(32'(read_address[9:0])) : 32'hDEADBEEF;

    // ---------------- reference model -------------------------------------
    logic [31:0] ref_mem [DEPTH];
    bit          m_busy;
    bit          m_owner;
    bit          m_last;
    int          m_run;
    logic [31:0] exp_rdata  [2];
    bit          exp_rvalid [2];

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // last observed values (sampled at negedge in step)
    logic o_g0, o_g1, o_we, o_rv0, o_rv1;
    logic [31:0] o_rd0, o_rd1;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 1; m_run = 0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        exp_rvalid[0] = 0; exp_rvalid[1] = 0;
    endtask

    task automatic set_port(int p, logic r, logic w, logic [31:0] a, logic [31:0] d);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic clear_inputs();
        set_port(0, 0, 0, '0, '0);
        set_port(1, 0, 0, '0, '0);
    endtask

    // One clock cycle: compare everything at negedge, advance the model,
    // then return 1 time unit after the next posedge.
    task automatic step(string tag);
        bit r[2], w[2], o, req_o, req_x, we_o, xfer, inr;
        logic [31:0] a[2], d[2], a_o, d_o;
        @(negedge clk);
        r[0] = bus.req0;  r[1] = bus.req1;
        w[0] = bus.we0;   w[1] = bus.we1;
        a[0] = bus.addr0; a[1] = bus.addr1;
        d[0] = bus.wdata0; d[1] = bus.wdata1;
        o     = m_owner;
        req_o = r[o]; req_x = r[!o]; we_o = w[o]; a_o = a[o]; d_o = d[o];
        xfer  = m_busy && req_o;
        inr   = a_o < 32'(DEPTH);

        check({tag, ".gnt0"}, 64'(bus.gnt0), 64'(xfer && o == 0));
        check({tag, ".gnt1"}, 64'(bus.gnt1), 64'(xfer && o == 1));
        check({tag, ".we"},   64'(write_enable), 64'(xfer && we_o && inr));
        check({tag, ".raddr"}, 64'(read_address),  64'(m_busy ? a_o : 32'h0));
        check({tag, ".waddr"}, 64'(write_address), 64'(m_busy ? a_o : 32'h0));
        check({tag, ".din"},   64'(data_in),       64'(m_busy ? d_o : 32'h0));
        check({tag, ".rv0"}, 64'(bus.rvalid0), 64'(exp_rvalid[0]));
        check({tag, ".rv1"}, 64'(bus.rvalid1), 64'(exp_rvalid[1]));
        check({tag, ".rd0"}, 64'(bus.rdata0), 64'(exp_rdata[0]));
        check({tag, ".rd1"}, 64'(bus.rdata1), 64'(exp_rdata[1]));

        o_g0 = bus.gnt0; o_g1 = bus.gnt1; o_we = write_enable;
        o_rv0 = bus.rvalid0; o_rv1 = bus.rvalid1;
        o_rd0 = bus.rdata0;  o_rd1 = bus.rdata1;

        exp_rvalid[0] = 0; exp_rvalid[1] = 0;
        if (xfer) begin
            if (we_o) begin
                if (inr) ref_mem[a_o[9:0]] = d_o;
            end else begin
                exp_rdata[o]  = inr ? ref_mem[a_o[9:0]] : 32'h0;
                exp_rvalid[o] = 1;
            end
        end

        if (!m_busy) begin
            if (r[0] || r[1]) begin
                m_busy  = 1;
                m_run   = 0;
                m_owner = (r[0] && r[1]) ? !m_last : r[1];
            end
        end else if (xfer) begin
            m_run++;
            if (m_run >= BURST_MAX && req_x) begin
                m_last = o; m_owner = !o; m_run = 0;
            end
        end else if (req_x) begin
            m_last = o; m_owner = !o; m_run = 0;
        end else begin
            m_busy = 0; m_last = o;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst.gnt0", 64'(bus.gnt0), 64'h0);
        check("rst.gnt1", 64'(bus.gnt1), 64'h0);
        check("rst.we",   64'(write_enable), 64'h0);
        check("rst.raddr", 64'(read_address), 64'h0);
        check("rst.rv0",  64'(bus.rvalid0), 64'h0);
        check("rst.rv1",  64'(bus.rvalid1), 64'h0);
        check("rst.rd0",  64'(bus.rdata0), 64'h0);
        check("rst.rd1",  64'(bus.rdata1), 64'h0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [11:0] g0s, g1s;
        logic [31:0] old7;
        bit pend[2];
        int bad;

        for (int unsigned i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // lone port 1 streams reads of addr 1..10
        set_port(1, 1, 0, 32'd1, '0);
        step("str.idle");
        check("str.idle_gnt1", 64'(o_g1), 64'h0);
        for (int k = 0; k < 10; k++) begin
            step("str");
            check("str.gnt1", 64'(o_g1), 64'h1);
            if (k >= 1) check("str.rdata1", 64'(o_rd1), 64'(stream_vals[k-1]));
            set_port(1, 1, 0, 32'(k + 2), '0);
        end
        set_port(1, 0, 0, '0, '0);
        step("str.tail");
        check("str.last_rv1", 64'(o_rv1), 64'h1);
        check("str.last_rd1", 64'(o_rd1), 64'(stream_vals[9]));
        step("str.drop");

        // write addr 5 then read it back on port 0
        do_reset();
        set_port(0, 1, 1, 32'd5, 32'h1234);
        step("wr.c1");
        check("wr.c1_gnt0", 64'(o_g0), 64'h0);
        step("wr.c2");
        check("wr.c2_gnt0", 64'(o_g0), 64'h1);
        check("wr.c2_we",   64'(o_we), 64'h1);
        check("wr.mem5",    64'(mem_view(5)), 64'h1234);
        set_port(0, 1, 0, 32'd5, '0);
        step("rd.gnt");
        check("rd.gnt0", 64'(o_g0), 64'h1);
        set_port(0, 0, 0, '0, '0);
        step("rd.resp");
        check("rd.rv0", 64'(o_rv0), 64'h1);
        check("rd.rd0", 64'(o_rd0), 64'h1234);
        step("rd.after");
        check("rd.rv0_pulse", 64'(o_rv0), 64'h0);

        // both ports held: 4/4/4 rotation starting with port 0
        do_reset();
        set_port(0, 1, 0, 32'd20, '0);
        set_port(1, 1, 0, 32'd30, '0);
        step("bur.idle");
        for (int i = 0; i < 12; i++) begin
            step("bur");
            g0s[i] = o_g0;
            g1s[i] = o_g1;
        end
        check("bur.gnt0_pattern", 64'(g0s), 64'hF0F);
        check("bur.gnt1_pattern", 64'(g1s), 64'h0F0);
        check("bur.never_both",   64'(g0s & g1s), 64'h0);
        clear_inputs();
        step("bur.drop1");
        step("bur.drop2");

        // port 0 drops after two transfers with port 1 pending
        do_reset();
        set_port(0, 1, 0, 32'd40, '0);
        set_port(1, 1, 1, 32'd41, 32'hABCD);
        step("dead.idle");
        step("dead.t1");
        step("dead.t2");
        check("dead.t2_gnt0", 64'(o_g0), 64'h1);
        set_port(0, 0, 0, '0, '0);
        step("dead.slot");
        check("dead.slot_gnt0", 64'(o_g0), 64'h0);
        check("dead.slot_gnt1", 64'(o_g1), 64'h0);
        check("dead.slot_we",   64'(o_we), 64'h0);
        step("dead.p1");
        check("dead.p1_gnt1", 64'(o_g1), 64'h1);
        check("dead.p1_we",   64'(o_we), 64'h1);
        clear_inputs();
        step("dead.end");

        // out-of-range write and read
        do_reset();
        set_port(0, 1, 1, 32'd1024, 32'hCAFE);
        step("oor.idle");
        step("oor.wr");
        check("oor.wr_gnt0", 64'(o_g0), 64'h1);
        check("oor.wr_we",   64'(o_we), 64'h0);
        set_port(0, 1, 0, 32'd2000, '0);
        step("oor.rd");
        set_port(0, 0, 0, '0, '0);
        step("oor.resp");
        check("oor.rv0", 64'(o_rv0), 64'h1);
        check("oor.rd0", 64'(o_rd0), 64'h0);

        // asynchronous reset in the middle of a granted write
        do_reset();
        old7 = mem_view(7);
        set_port(0, 1, 1, 32'd7, 32'h7777);
        step("arst.idle");
        @(negedge clk);
        #1;
        check("arst.pre_gnt0", 64'(bus.gnt0), 64'h1);
        check("arst.pre_we",   64'(write_enable), 64'h1);
        rst = 1'b1;
        #1;
        check("arst.gnt0", 64'(bus.gnt0), 64'h0);
        check("arst.we",   64'(write_enable), 64'h0);
        check("arst.raddr", 64'(read_address), 64'h0);
        @(posedge clk);
        #1;
        check("arst.mem7", 64'(mem_view(7)), 64'(old7));
        rst = 1'b0;
        model_reset();
        set_port(0, 1, 0, 32'd8, '0);
        set_port(1, 1, 0, 32'd9, '0);
        step("arst.idle2");
        step("arst.first");
        check("arst.first_gnt0", 64'(o_g0), 64'h1);
        clear_inputs();
        step("arst.drop");

        // randomized traffic against the model
        pend[0] = 0; pend[1] = 0;
        o_g0 = 0; o_g1 = 0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] || (p == 0 ? o_g0 : o_g1)) begin
                    pend[p] = $urandom_range(0, 99) < 60;
                    set_port(p, pend[p], 1'($urandom_range(0, 1)),
                             ($urandom_range(0, 15) == 0) ? 32'(1000 + $urandom_range(0, 100))
                                                          : 32'($urandom_range(0, 63)),
                             $urandom);
                end else if ($urandom_range(0, 19) == 0) begin
                    pend[p] = 0;
                    if (p == 0) bus.req0 = 1'b0;
                    else        bus.req1 = 1'b0;
                end
            end
            step("rnd");
        end
        clear_inputs();
        step("rnd.drain1");
        step("rnd.drain2");

        bad = 0;
        for (int unsigned i = 0; i < DEPTH; i++)
            if (mem_view(i) !== ref_mem[i]) bad++;
        check("final.mem_mismatches", 64'(bad), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
